// File: rtl/mlaccel_qpi_host.sv
// rtl/mlaccel_qpi_host.sv - QPI bus master serialising a byte command stream onto csb/clk/io[3:0]
//
// Ports:
//   clock, reset          system clock, synchronous active-high reset
//   cmd_valid/cmd_ready   byte command handshake; cmd_data/cmd_read/cmd_last qualify the byte
//   rsp_valid/rsp_data    one-cycle pulse with a captured read byte
//   busy                  high from the first accepted byte until the chip-select gap ends
//   qpi_csb, qpi_clk      registered QPI chip select (active low) and clock
//   qpi_io_do/qpi_io_oe   registered io drive data and enable (all enable bits equal)
//   qpi_io_di             io sample data from the slave
module mlaccel_qpi_host #(
    parameter int CLKDIV  = 2,
    parameter int CSB_GAP = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [7:0] cmd_data,
    input  logic       cmd_read,
    input  logic       cmd_last,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       busy,
    output logic       qpi_csb,
    output logic       qpi_clk,
    output logic [3:0] qpi_io_do,
    output logic [3:0] qpi_io_oe,
    input  logic [3:0] qpi_io_di
);

    localparam int HC_MAX = (CLKDIV > CSB_GAP) ? CLKDIV : CSB_GAP;
    localparam int HCW    = $clog2(HC_MAX + 1);
    localparam logic [HCW-1:0] HC_CLK = HCW'(CLKDIV - 1);
    localparam logic [HCW-1:0] HC_GAP = HCW'(CSB_GAP - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LO0, S_HI0, S_LO1, S_HI1, S_WAIT, S_END, S_GAP
    } state_t;

    state_t         state, state_nx;
    logic [HCW-1:0] hc, hc_nx;
    logic [7:0]     dat_q, dat_nx;
    logic           rd_q, rd_nx;
    logic           lst_q, lst_nx;
    logic           csb_nx, clk_nx, rsp_valid_nx;
    logic [7:0]     rsp_data_nx;
    logic [3:0]     do_nx, oe_nx;
    logic           accept, hc_zero;

    assign cmd_ready = ((state == S_IDLE) || (state == S_WAIT)) && !reset;
    assign accept    = cmd_valid && cmd_ready;
    assign hc_zero   = (hc == '0);
    assign busy      = (state != S_IDLE);

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= S_IDLE;
            hc        <= '0;
            dat_q     <= 8'h00;
            rd_q      <= 1'b0;
            lst_q     <= 1'b0;
            qpi_csb   <= 1'b1;
            qpi_clk   <= 1'b0;
            qpi_io_do <= 4'h0;
            qpi_io_oe <= 4'h0;
            rsp_valid <= 1'b0;
            rsp_data  <= 8'h00;
        end else begin
            state     <= state_nx;
            hc        <= hc_nx;
            dat_q     <= dat_nx;
            rd_q      <= rd_nx;
            lst_q     <= lst_nx;
            qpi_csb   <= csb_nx;
            qpi_clk   <= clk_nx;
            qpi_io_do <= do_nx;
            qpi_io_oe <= oe_nx;
            rsp_valid <= rsp_valid_nx;
            rsp_data  <= rsp_data_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (accept) state_nx = S_LO0;
            S_LO0:   if (hc_zero) state_nx = S_HI0;
            S_HI0:   if (hc_zero) state_nx = S_LO1;
            S_LO1:   if (hc_zero) state_nx = S_HI1;
            S_HI1:   if (hc_zero) state_nx = lst_q ? S_END : S_WAIT;
            S_WAIT:  if (accept) state_nx = S_LO0;
            S_END:   if (hc_zero) state_nx = S_GAP;
            S_GAP:   if (hc_zero) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Next values for every registered pin, so nothing combinational reaches the pads.
    always_comb begin
        hc_nx        = hc;
        dat_nx       = dat_q;
        rd_nx        = rd_q;
        lst_nx       = lst_q;
        csb_nx       = qpi_csb;
        do_nx        = qpi_io_do;
        oe_nx        = qpi_io_oe;
        rsp_valid_nx = 1'b0;
        rsp_data_nx  = rsp_data;
        clk_nx       = (state_nx == S_HI0) || (state_nx == S_HI1);

        // One shared down-counter: reload on every state change, GAP uses its own length.
        if (state_nx != state) begin
            hc_nx = (state_nx == S_GAP) ? HC_GAP : HC_CLK;
        end else if (!hc_zero) begin
            hc_nx = hc - HCW'(1);
        end

        if (accept) begin
            dat_nx = cmd_data;
            rd_nx  = cmd_read;
            lst_nx = cmd_last;
            csb_nx = 1'b0;
            // A read releases io from its first low phase, giving the slave a turnaround.
            oe_nx  = cmd_read ? 4'h0 : 4'hF;
            if (!cmd_read) do_nx = cmd_data[7:4];
        end

        if ((state == S_HI0) && hc_zero && !rd_q) begin
            do_nx = dat_q[3:0];
        end

        // Capture on the edge that raises qpi_clk; the slave has held data since the low phase.
        if ((state == S_LO0) && hc_zero && rd_q) begin
            rsp_data_nx[7:4] = qpi_io_di;
        end
        if ((state == S_LO1) && hc_zero && rd_q) begin
            rsp_data_nx[3:0] = qpi_io_di;
            rsp_valid_nx     = 1'b1;
        end

        if ((state == S_END) && hc_zero) begin
            csb_nx = 1'b1;
            do_nx  = 4'h0;
            oe_nx  = 4'h0;
        end
    end

endmodule
